// File: rtl/stack_ctrl_8_if.sv
// stack_ctrl_8_if
//   Bundles the datapath-facing and RAM-facing signals of stack_ctrl_8.
//   master : the datapath plus RAM_8 side (drives requests and RAM_Q)
//   slave  : the stack controller (drives status, popped data, RAM pins)
// Signals:
//   PUSH, POP, CLR_ERR, DATA_I    requests and the word to push
//   DATA_O, VALID_O               registered popped word and its pulse
//   COUNT, EMPTY, FULL, OVF, UNF  occupancy and sticky error status
//   RAM_D/W/R/E/ADDR, RAM_Q       RAM_8 pins
interface stack_ctrl_8_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             PUSH;
  logic             POP;
  logic             CLR_ERR;
  logic [WIDTH-1:0] DATA_I;
  logic [WIDTH-1:0] DATA_O;
  logic             VALID_O;
  logic [AW:0]      COUNT;
  logic             EMPTY;
  logic             FULL;
  logic             OVF;
  logic             UNF;
  logic [WIDTH-1:0] RAM_D;
  logic             RAM_W;
  logic             RAM_R;
  logic             RAM_E;
  logic [AW-1:0]    RAM_ADDR;
  logic [WIDTH-1:0] RAM_Q;

  modport master (
    output PUSH, POP, CLR_ERR, DATA_I, RAM_Q,
    input  DATA_O, VALID_O, COUNT, EMPTY, FULL, OVF, UNF,
    input  RAM_D, RAM_W, RAM_R, RAM_E, RAM_ADDR
  );

  modport slave (
    input  PUSH, POP, CLR_ERR, DATA_I, RAM_Q,
    output DATA_O, VALID_O, COUNT, EMPTY, FULL, OVF, UNF,
    output RAM_D, RAM_W, RAM_R, RAM_E, RAM_ADDR
  );
endinterface

// File: rtl/stack_ctrl_8.sv
// stack_ctrl_8
//   LIFO controller in front of the 8 x 16 RAM_8 block. Owns the entry
//   count (which doubles as the stack pointer), full/empty decode and the
//   sticky OVF/UNF flags. RAM pins are driven combinationally within the
//   cycle; the RAM writes at the rising edge and reads combinationally, so a
//   pop captures RAM_Q into DATA_O at the same edge (1-cycle latency).
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset; also gates RAM W/R/E off while high
//   bus  stack_ctrl_8_if.slave (requests, status, popped data, RAM pins)
//
// Decoded operation per cycle:
//   op            | meaning
//   OP_IDLE       | no request, RAM untouched
//   OP_PUSH       | push, not full: write DATA_I at COUNT, COUNT+1
//   OP_PUSH_FULL  | push while full: dropped, OVF set
//   OP_POP        | pop, not empty: read COUNT-1, COUNT-1, VALID_O
//   OP_POP_EMPTY  | pop while empty: dropped, UNF set
//   OP_REPLACE    | push+pop, not empty: read old top, overwrite it
//   OP_PUSH_EMPTY | push+pop while empty: acts as push, UNF set
module stack_ctrl_8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic           CLK,
  input logic           RST,
  stack_ctrl_8_if.slave bus
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY,
    OP_REPLACE,
    OP_PUSH_EMPTY
  } op_e;

  op_e              op;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty, full;
  logic [AW-1:0]    top_addr;
  logic             ram_e, ram_w, ram_r;
  logic [AW-1:0]    ram_addr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Modulo-2^AW arithmetic; only used when count_q >= 1.
  assign top_addr = count_q[AW-1:0] - ADDR_ONE;

  always_comb begin
    op = OP_IDLE;
    case ({bus.PUSH, bus.POP})
      2'b10:   op = full  ? OP_PUSH_FULL  : OP_PUSH;
      2'b01:   op = empty ? OP_POP_EMPTY  : OP_POP;
      2'b11:   op = empty ? OP_PUSH_EMPTY : OP_REPLACE;
      default: op = OP_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state select. A new error in the same cycle as CLR_ERR wins,
  // because the set is applied after the clear.
  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q & ~bus.CLR_ERR;
    unf_d   = unf_q & ~bus.CLR_ERR;
    case (op)
      OP_PUSH: begin
        count_d = count_q + CNT_ONE;
      end
      OP_PUSH_FULL: begin
        ovf_d = 1'b1;
      end
      OP_POP: begin
        count_d = count_q - CNT_ONE;
        data_d  = bus.RAM_Q;
        valid_d = 1'b1;
      end
      OP_POP_EMPTY: begin
        unf_d = 1'b1;
      end
      OP_REPLACE: begin
        // RAM_Q still shows the old top: the overwrite lands at the edge.
        data_d  = bus.RAM_Q;
        valid_d = 1'b1;
      end
      OP_PUSH_EMPTY: begin
        count_d = count_q + CNT_ONE;
        unf_d   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // RAM pin drive
  always_comb begin
    ram_e    = 1'b0;
    ram_w    = 1'b0;
    ram_r    = 1'b0;
    ram_addr = '0;
    case (op)
      OP_PUSH, OP_PUSH_EMPTY: begin
        ram_e    = 1'b1;
        ram_w    = 1'b1;
        ram_addr = count_q[AW-1:0];
      end
      OP_POP: begin
        ram_e    = 1'b1;
        ram_r    = 1'b1;
        ram_addr = top_addr;
      end
      OP_REPLACE: begin
        ram_e    = 1'b1;
        ram_r    = 1'b1;
        ram_w    = 1'b1;
        ram_addr = top_addr;
      end
      default: begin
      end
    endcase
    // A reset landing on a push must not corrupt the RAM.
    if (RST) begin
      ram_e = 1'b0;
      ram_w = 1'b0;
      ram_r = 1'b0;
    end
  end

  assign bus.RAM_E    = ram_e;
  assign bus.RAM_W    = ram_w;
  assign bus.RAM_R    = ram_r;
  assign bus.RAM_ADDR = ram_addr;
  assign bus.RAM_D    = bus.DATA_I;

  assign bus.DATA_O  = data_q;
  assign bus.VALID_O = valid_q;
  assign bus.COUNT   = count_q;
  assign bus.EMPTY   = empty;
  assign bus.FULL    = full;
  assign bus.OVF     = ovf_q;
  assign bus.UNF     = unf_q;

endmodule

// File: tb/tb_stack_ctrl_8.sv
// tb_stack_ctrl_8
//   Drives stack_ctrl_8 through directed scenarios and a randomized run,
//   with a behavioural RAM_8 attached and a queue-based LIFO reference.
module tb_stack_ctrl_8;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic CLK = 1'b0;
  logic RST;

  stack_ctrl_8_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  stack_ctrl_8 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM_8: edge write when W and E, combinational read.
  logic [WIDTH-1:0] mem [DEPTH];
  assign bus.RAM_Q = mem[bus.RAM_ADDR];
  always @(posedge CLK) begin
    if (bus.RAM_E && bus.RAM_W) mem[bus.RAM_ADDR] <= bus.RAM_D;
  end

  // Reference model
  logic [WIDTH-1:0] m_stk [$];
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ovf;
  logic             m_unf;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit push, input bit pop, input bit clr, input bit rst,
                      input logic [WIDTH-1:0] d);
    int sz;
    bit e_e, e_w, e_r, o_set, u_set;
    int e_addr;
    RST         = rst;
    bus.PUSH    = push;
    bus.POP     = pop;
    bus.CLR_ERR = clr;
    bus.DATA_I  = d;
    #1;
    sz     = m_stk.size();
    e_e    = 1'b0;
    e_w    = 1'b0;
    e_r    = 1'b0;
    e_addr = 0;
    if (!rst) begin
      if (push && !pop && sz < DEPTH) begin
        e_e = 1'b1; e_w = 1'b1; e_addr = sz;
      end else if (!push && pop && sz > 0) begin
        e_e = 1'b1; e_r = 1'b1; e_addr = sz - 1;
      end else if (push && pop) begin
        e_e = 1'b1; e_w = 1'b1; e_r = (sz > 0); e_addr = (sz > 0) ? sz - 1 : 0;
      end
    end
    check("ram_e", 32'(bus.RAM_E), 32'(e_e));
    check("ram_w", 32'(bus.RAM_W), 32'(e_w));
    check("ram_r", 32'(bus.RAM_R), 32'(e_r));
    if (e_e || (!push && !pop)) check("ram_addr", 32'(bus.RAM_ADDR), 32'(e_addr));
    if (e_w) check("ram_d", 32'(bus.RAM_D), 32'(d));

    @(posedge CLK);
    if (rst) begin
      m_stk.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      o_set   = 1'b0;
      u_set   = 1'b0;
      m_valid = 1'b0;
      if (push && !pop) begin
        if (sz < DEPTH) m_stk.push_back(d);
        else o_set = 1'b1;
      end else if (!push && pop) begin
        if (sz > 0) begin
          m_data  = m_stk.pop_back();
          m_valid = 1'b1;
        end else u_set = 1'b1;
      end else if (push && pop) begin
        if (sz > 0) begin
          m_data         = m_stk[sz-1];
          m_stk[sz-1]    = d;
          m_valid        = 1'b1;
        end else begin
          m_stk.push_back(d);
          u_set = 1'b1;
        end
      end
      m_ovf = (m_ovf && !clr) || o_set;
      m_unf = (m_unf && !clr) || u_set;
    end
    #1;
    check("count",   32'(bus.COUNT),   32'(m_stk.size()));
    check("empty",   32'(bus.EMPTY),   32'(m_stk.size() == 0));
    check("full",    32'(bus.FULL),    32'(m_stk.size() == DEPTH));
    check("ovf",     32'(bus.OVF),     32'(m_ovf));
    check("unf",     32'(bus.UNF),     32'(m_unf));
    check("valid_o", 32'(bus.VALID_O), 32'(m_valid));
    check("data_o",  32'(bus.DATA_O),  32'(m_data));
  endtask

  initial begin
    int bias;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    RST = 1'b1; bus.PUSH = 1'b0; bus.POP = 1'b0; bus.CLR_ERR = 1'b0; bus.DATA_I = '0;

    // Reset
    step(0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 1, 16'h0);

    // Fill 1..8, overflow, clear
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 0, 16'(i));
    step(1, 0, 0, 0, 16'd9);
    step(0, 0, 1, 0, 16'h0);

    // Drain 8..1, then idle so VALID_O drops
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);

    // Underflow holds DATA_O
    step(0, 1, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);

    // Replace top
    step(1, 0, 0, 0, 16'd5);
    step(1, 0, 0, 0, 16'd6);
    step(1, 1, 0, 0, 16'd9);
    step(0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);

    // Replace while full, error set and clear together, push+pop on empty
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 16'(16'h100 + i));
    step(1, 1, 0, 0, 16'hBEEF);
    step(1, 0, 1, 0, 16'h1234);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 16'h0);
    step(1, 1, 0, 0, 16'h00AA);
    step(0, 1, 0, 0, 16'h0);

    // Push with reset in the same cycle, then pop
    step(1, 0, 0, 0, 16'd7);
    step(1, 0, 0, 1, 16'd3);
    step(0, 1, 0, 0, 16'h0);

    // Randomized traffic with phases biased toward filling or draining
    bias = 70;
    for (int n = 0; n < 800; n++) begin
      if (n % 40 == 0) bias = (bias == 70) ? 30 : 70;
      step(($urandom_range(0, 99) < bias),
           ($urandom_range(0, 99) < (100 - bias)),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 79) == 0),
           16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
